// File: rtl/uart_tx_frame_cfg.sv
// uart_tx_frame_cfg: configurable UART transmitter (5..8 data bits, none/even/odd
// parity, 1/2 stop bits) fed by a small byte FIFO with valid/ready upstream.
// Frames go out LSB first; back-to-back frames have no idle gap between them.
module uart_tx_frame_cfg #(
    parameter int CLK_MHZ    = 50,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic                              up_valid,
    output logic                              up_ready,
    input  logic [7:0]                        up_data,
    output logic                              tx,
    output logic                              busy,
    output logic                              frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    // Clocks per bit; computed wide so large CLK_MHZ values cannot overflow.
    localparam longint DIV_L = (longint'(CLK_MHZ) * 64'd1_000_000) / longint'(BAUDRATE);
    localparam int     DIV   = int'(DIV_L);
    localparam int     CW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int     AW    = $clog2(FIFO_DEPTH);
    localparam int     LW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] LAST_CNT  = CW'(DIV - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0]    MASK      = 8'((1 << DATA_BITS) - 1);
    localparam logic          PAR_INV   = (PARITY == 2);
    localparam logic          HAS_PAR   = (PARITY != 0);

    // Reject illegal configurations at elaboration time.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_frame_cfg: DIV must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
            $error("uart_tx_frame_cfg: DATA_BITS must be 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_tx_frame_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_frame_cfg: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_frame_cfg: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    // ---------------- byte FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          push, pop, fifo_empty;
    logic [7:0]    head;

    // Ready depends only on registered level, so a full FIFO refuses a push
    // even in a cycle where the transmitter pops.
    assign up_ready   = (level != LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign push       = up_valid && up_ready;
    assign head       = mem[rd_ptr] & MASK;
    assign fifo_level = level;

    // Storage array carries no reset; only pointers/level define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= up_data;
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // ---------------- transmit FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          par_bit;

    assign bit_end = (cnt_q == LAST_CNT);
    // Byte is masked at latch time, so the XOR covers exactly the sent bits.
    assign par_bit = (^byte_q) ^ PAR_INV;
    assign tx      = tx_q;
    assign busy    = (state_q != S_IDLE);

    // State, baud counter, bit index, held byte and line register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line value for the following cycle, so the
    // line switches on the same edge the state does.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        frame_done = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    byte_d  = head;
                    state_d = S_START;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = byte_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_q[bit_d];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        bit_d      = '0;
                        // Chain straight into the next frame when data waits.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            byte_d  = head;
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_cfg.sv
// Bench for uart_tx_frame_cfg: four configurations (8N1, 8E1, 8O1, 7N2) at DIV=10,
// directed frames with hand-computed bit patterns, FIFO flow control and reset.
module tb_uart_tx_frame_cfg;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       arstn;
    logic [3:0] uv;
    logic [7:0] ud [4];
    wire  [3:0] rdy_w, tx_w, busy_w, fd_w;
    wire  [2:0] lvl_w [4];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fb [7] = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hF0, 8'h0F, 8'hA5};

    always #5 clk = ~clk;

    // 8N1
    uart_tx_frame_cfg #(.CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .clk(clk), .arstn(arstn), .up_valid(uv[0]), .up_ready(rdy_w[0]), .up_data(ud[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]), .fifo_level(lvl_w[0]));
    // 8E1
    uart_tx_frame_cfg #(.CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(8), .PARITY(1),
        .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
        .clk(clk), .arstn(arstn), .up_valid(uv[1]), .up_ready(rdy_w[1]), .up_data(ud[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]), .fifo_level(lvl_w[1]));
    // 8O1
    uart_tx_frame_cfg #(.CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
        .clk(clk), .arstn(arstn), .up_valid(uv[2]), .up_ready(rdy_w[2]), .up_data(ud[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]), .fifo_level(lvl_w[2]));
    // 7N2
    uart_tx_frame_cfg #(.CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(7), .PARITY(0),
        .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
        .clk(clk), .arstn(arstn), .up_valid(uv[3]), .up_ready(rdy_w[3]), .up_data(ud[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]), .fifo_level(lvl_w[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Walks one frame cycle by cycle from a negedge; pat bit k is line bit k.
    task automatic check_frame(input int d, input logic [15:0] pat, input int nbits,
                               input bit wait_start, input string tag, output int waited);
        int e_tx, e_busy, e_fd;
        e_tx = 0; e_busy = 0; e_fd = 0; waited = 0;
        if (wait_start) begin
            while (tx_w[d] !== 1'b0 && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            chk({tag, "_start"}, tx_w[d], 0);
        end
        for (int k = 0; k < nbits * DIV; k++) begin
            if (tx_w[d] !== pat[k / DIV]) e_tx++;
            if (busy_w[d] !== 1'b1) e_busy++;
            if (fd_w[d] !== (k == nbits * DIV - 1)) e_fd++;
            @(negedge clk);
        end
        chk({tag, "_tx_errs"}, e_tx, 0);
        chk({tag, "_busy_errs"}, e_busy, 0);
        chk({tag, "_done_errs"}, e_fd, 0);
    endtask

    task automatic send_one(input int d, input logic [7:0] b, input logic [15:0] pat,
                            input int nbits, input string tag);
        int w;
        @(negedge clk);
        uv[d] = 1'b1; ud[d] = b;
        @(posedge clk);
        @(negedge clk);
        uv[d] = 1'b0; ud[d] = 8'h00;
        chk({tag, "_lvl1"}, lvl_w[d], 1);
        chk({tag, "_idle_tx"}, tx_w[d], 1);
        check_frame(d, pat, nbits, 1'b1, tag, w);
        chk({tag, "_lat"}, w, 1);
        chk({tag, "_busy_end"}, busy_w[d], 0);
        chk({tag, "_tx_end"}, tx_w[d], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0;
        uv = '0;
        for (int i = 0; i < 4; i++) ud[i] = 8'h00;
        #23;
        chk("rst_tx", tx_w[0], 1);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_done", fd_w[0], 0);
        chk("rst_lvl", lvl_w[0], 0);
        chk("rst_ready", rdy_w[0], 1);
        @(negedge clk); arstn = 1'b1;
        @(negedge clk);
        chk("post_rel_tx", tx_w[3], 1);
        chk("post_rel_busy", busy_w[3], 0);

        // single frames, hand-derived patterns (bit0 = start)
        send_one(0, 8'h55, 16'h02AA, 10, "n1_55");
        send_one(1, 8'h55, 16'h04AA, 11, "e1_55");
        send_one(1, 8'h01, 16'h0602, 11, "e1_01");
        send_one(2, 8'h01, 16'h0402, 11, "o1_01");
        send_one(3, 8'hFF, 16'h03FE, 10, "n2_ff");
        send_one(3, 8'h80, 16'h0300, 10, "n2_80");

        // FIFO flow control with contiguous frames
        fork
            begin : pusher
                int idx;
                bit rdy, pfd, first_fd, seen;
                logic [2:0] plvl;
                idx = 0; first_fd = 1'b1; seen = 1'b0;
                @(negedge clk);
                uv[0] = 1'b1; ud[0] = fb[0];
                for (int c = 0; c < 400 && idx < 6; c++) begin
                    rdy = rdy_w[0]; plvl = lvl_w[0]; pfd = fd_w[0];
                    if (pfd && first_fd) begin
                        chk("fifo_acc_before_done", idx, 5);
                        first_fd = 1'b0;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    if (rdy) begin
                        idx++;
                        if (idx == 5) begin
                            chk("fifo_full_ready", rdy_w[0], 0);
                            chk("fifo_full_lvl", lvl_w[0], 4);
                        end
                        if (idx == 6) chk("fifo_refill_lvl", lvl_w[0], 4);
                        if (idx < 6) ud[0] = fb[idx];
                        else uv[0] = 1'b0;
                    end else if (plvl == 3'd4 && pfd) begin
                        chk("fifo_full_pushpop_lvl", lvl_w[0], 3);
                        seen = 1'b1;
                    end
                end
                chk("fifo_all_accepted", idx, 6);
                chk("fifo_full_pushpop_seen", seen, 1);
                for (int c = 0; c < 1000 && !(lvl_w[0] == 3'd2 && fd_w[0] == 1'b1); c++)
                    @(negedge clk);
                chk("fifo_l2_found", fd_w[0], 1);
                uv[0] = 1'b1; ud[0] = fb[6];
                @(posedge clk);
                @(negedge clk);
                uv[0] = 1'b0;
                chk("fifo_l2_pushpop_lvl", lvl_w[0], 2);
            end
            begin : monitor
                int w;
                @(negedge clk);
                for (int i = 0; i < 7; i++)
                    check_frame(0, {6'h00, 1'b1, fb[i], 1'b0}, 10, (i == 0),
                                $sformatf("fifo_f%0d", i), w);
                chk("fifo_drain_busy", busy_w[0], 0);
                chk("fifo_drain_lvl", lvl_w[0], 0);
            end
        join

        // reset in the middle of a data bit with one byte still queued
        @(negedge clk);
        uv[0] = 1'b1; ud[0] = 8'h5A;
        @(posedge clk); @(negedge clk);
        ud[0] = 8'hC3;
        @(posedge clk); @(negedge clk);
        uv[0] = 1'b0;
        repeat (35) @(negedge clk);
        chk("rst_pre_busy", busy_w[0], 1);
        chk("rst_pre_lvl", lvl_w[0], 1);
        chk("rst_pre_tx", tx_w[0], 0);
        #2 arstn = 1'b0;
        #1;
        chk("rst_mid_tx", tx_w[0], 1);
        chk("rst_mid_busy", busy_w[0], 0);
        chk("rst_mid_lvl", lvl_w[0], 0);
        chk("rst_mid_ready", rdy_w[0], 1);
        chk("rst_mid_done", fd_w[0], 0);
        @(negedge clk); arstn = 1'b1;
        send_one(0, 8'hA3, 16'h0346, 10, "post_rst_a3");
        repeat (5) @(negedge clk);
        chk("post_rst_idle_tx", tx_w[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
